read_ptr_fwft: RTL



---
 rtl/fifo_pkg.sv | 25 ++
 rtl/read_out_buf.sv | 64 ++++++
 rtl/read_ptr_fwft.sv | 123 ++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared async-FIFO package: default geometry and Gray/binary conversion helpers.
// Both helpers work on zero-extended values up to GRAY_W_MAX bits. The extra zero
// MSBs do not change the result, so callers cast to and from their own pointer width.
package fifo_pkg;

  localparam int unsigned FIFO_ADDRSIZE = 9;
  localparam int unsigned FIFO_DATASIZE = 8;
  localparam int unsigned GRAY_W_MAX    = 32;

  // Binary to reflected Gray code.
  function automatic logic [GRAY_W_MAX-1:0] bin2gray(input logic [GRAY_W_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: each bit is the XOR of itself and every Gray bit above it.
  function automatic logic [GRAY_W_MAX-1:0] gray2bin(input logic [GRAY_W_MAX-1:0] g);
    logic [GRAY_W_MAX-1:0] b;
    b[GRAY_W_MAX-1] = g[GRAY_W_MAX-1];
    for (int i = int'(GRAY_W_MAX) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/read_out_buf.sv
// Two-entry first-word-fall-through register FIFO for the read port.
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset
//   i_push, i_push_data : write a word (a simultaneous pop is allowed)
//   i_pop          : remove the head word (ignored when empty)
//   o_cnt          : number of held words, 0..2
//   o_head         : head word; it holds steady until popped
//   o_valid        : head word present
module read_out_buf
  import fifo_pkg::*;
#(
  parameter int unsigned DW = FIFO_DATASIZE
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic [DW-1:0] i_push_data,
  input  logic          i_pop,
  output logic [1:0]    o_cnt,
  output logic [DW-1:0] o_head,
  output logic          o_valid
);

  logic [1:0]    r_cnt;
  logic [DW-1:0] r_ent0;
  logic [DW-1:0] r_ent1;
  logic          w_pop;
  logic [1:0]    w_cnt_next;

  assign w_pop      = i_pop & (r_cnt != 2'd0);
  assign w_cnt_next = 2'(r_cnt + 2'(i_push) - 2'(w_pop));

  // The entry 0 register is always the head. A pop shifts entry 1 down.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= 2'd0;
      r_ent0 <= '0;
      r_ent1 <= '0;
    end else begin
      r_cnt <= w_cnt_next;
      case ({i_push, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_ent0 <= i_push_data;
          else               r_ent1 <= i_push_data;
        end
        2'b01: r_ent0 <= r_ent1;
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_ent0 <= i_push_data;
          end else begin
            r_ent0 <= r_ent1;
            r_ent1 <= i_push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_cnt   = r_cnt;
  assign o_head  = r_ent0;
  assign o_valid = (r_cnt != 2'd0);

endmodule

// File: rtl/read_ptr_fwft.sv
// Read-domain pointer, empty/level flags and FWFT output for the async FIFO.
// The module holds the binary and Gray read pointers and drives the synchronous
// memory read port. A 2-entry output buffer lets it sustain one word per cycle.
// Optional macro RPTR_LEVEL_EN: when defined, rlevel and raempty come from the
// synchronized write pointer through a gray2bin converter. When undefined, rlevel
// is 0 and raempty follows rempty.
// Ports:
//   rclk, r_rst_n : read clock, async active-low reset
//   wptr_sync     : Gray write pointer already synchronized into rclk
//   mem_rdata     : memory read data, one cycle after mem_ren
//   rd_ready      : consumer accepts rd_data
//   raddr, mem_ren: memory read address and combinational read enable
//   rptr          : registered Gray read pointer for the write domain
//   rempty, raempty, rlevel : registered empty, almost-empty and fill level
//   rd_valid, rd_data       : FWFT consumer interface
module read_ptr_fwft
  import fifo_pkg::*;
#(
  parameter int unsigned ADDRSIZE      = FIFO_ADDRSIZE,
  parameter int unsigned DATASIZE      = FIFO_DATASIZE,
  parameter int unsigned AEMPTY_THRESH = 4
) (
  input  logic                rclk,
  input  logic                r_rst_n,
  input  logic [ADDRSIZE:0]   wptr_sync,
  input  logic [DATASIZE-1:0] mem_rdata,
  input  logic                rd_ready,
  output logic [ADDRSIZE-1:0] raddr,
  output logic                mem_ren,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic                raempty,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                rd_valid,
  output logic [DATASIZE-1:0] rd_data
);

  localparam int unsigned PTR_W = ADDRSIZE + 1;

  logic [PTR_W-1:0] r_rbin;
  logic [PTR_W-1:0] r_rptr;
  logic             r_rempty;
  logic             r_inflight;

  logic [PTR_W-1:0] w_rbin_next;
  logic [PTR_W-1:0] w_rgray_next;
  logic [1:0]       w_obuf_cnt;
  logic             w_rd_valid;
  logic             w_pop;
  logic [2:0]       w_fill_next;

  // Fetch only while buffer plus in-flight words stay at most 2 after this edge.
  assign w_pop       = w_rd_valid & rd_ready;
  assign w_fill_next = 3'(3'(w_obuf_cnt) + 3'(r_inflight) - 3'(w_pop));
  assign mem_ren     = ~r_rempty & (w_fill_next <= 3'd1);

  assign w_rbin_next  = 2'(0) + PTR_W'(r_rbin + PTR_W'(mem_ren));
  assign w_rgray_next = PTR_W'(bin2gray(GRAY_W_MAX'(w_rbin_next)));

  // Pointer, empty flag and in-flight marker.
  always_ff @(posedge rclk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_rbin     <= '0;
      r_rptr     <= '0;
      r_rempty   <= 1'b1;
      r_inflight <= 1'b0;
    end else begin
      r_rbin     <= w_rbin_next;
      r_rptr     <= w_rgray_next;
      r_rempty   <= (w_rgray_next == wptr_sync);
      r_inflight <= mem_ren;
    end
  end

  assign raddr  = r_rbin[ADDRSIZE-1:0];
  assign rptr   = r_rptr;
  assign rempty = r_rempty;

`ifdef RPTR_LEVEL_EN
  logic [PTR_W-1:0] w_wbin_sync;
  logic [PTR_W-1:0] w_level_next;
  logic [PTR_W-1:0] r_rlevel;
  logic             r_raempty;

  // Modulo subtraction gives the unfetched word count, up to 2^ADDRSIZE.
  assign w_wbin_sync  = PTR_W'(gray2bin(GRAY_W_MAX'(wptr_sync)));
  assign w_level_next = w_wbin_sync - w_rbin_next;

  // Level and almost-empty registers.
  always_ff @(posedge rclk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_rlevel  <= '0;
      r_raempty <= 1'b1;
    end else begin
      r_rlevel  <= w_level_next;
      r_raempty <= (w_level_next <= PTR_W'(AEMPTY_THRESH));
    end
  end

  assign rlevel  = r_rlevel;
  assign raempty = r_raempty;
`else
  assign rlevel  = '0;
  assign raempty = r_rempty;
`endif

  // A word fetched on the previous cycle lands in the buffer at this edge.
  read_out_buf #(
    .DW(DATASIZE)
  ) u_obuf (
    .i_clk       (rclk),
    .i_rst_n     (r_rst_n),
    .i_push      (r_inflight),
    .i_push_data (mem_rdata),
    .i_pop       (w_pop),
    .o_cnt       (w_obuf_cnt),
    .o_head      (rd_data),
    .o_valid     (w_rd_valid)
  );

  assign rd_valid = w_rd_valid;

endmodule
